// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parameterised serial pattern detector:
// control-FSM encoding, length-port width and the legal-length test.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with a Mealy match pulse,
// overlapping / non-overlapping modes and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b0001_0110,
  parameter int                 DEF_LEN     = 5,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i,
  input  logic                           in_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           y,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           cfg_err
);

  localparam int              LW        = len_width(MAX_LEN);
  localparam logic [LW-1:0]   RST_LEN   = LW'(DEF_LEN);
  localparam state_t          RST_STATE = len_legal(DEF_LEN, MAX_LEN) ? ARMED : IDLE;

  state_t               state_reg, state_next;
  logic [MAX_LEN-1:0]   pattern_reg, pattern_next;
  logic [LW-1:0]        len_reg, len_next;
  logic                 overlap_reg, overlap_next;
  logic [MAX_LEN-2:0]   hist_reg, hist_next;
  logic [LW-1:0]        fill_reg, fill_next;
  logic                 err_reg, err_next;

  logic [MAX_LEN-1:0]   window;
  logic [MAX_LEN-1:0]   bit_ok;
  logic [LW:0]          fill_plus1;
  logic                 fill_ok;
  logic                 accept;
  logic                 legal;

  // Candidate window: stored history with the live bit as the youngest bit.
  assign window     = {hist_reg, i};
  assign fill_plus1 = {1'b0, fill_reg} + (LW+1)'(1);
  assign fill_ok    = fill_plus1 >= {1'b0, len_reg};
  assign accept     = rst_n && (state_reg == ARMED) && in_valid && !cfg_load;
  assign legal      = len_legal(int'(cfg_len), MAX_LEN);

  // Bits above the active length never take part in the comparison.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      assign bit_ok[gi] = (gi >= int'(len_reg)) || (window[gi] == pattern_reg[gi]);
    end
  endgenerate

  always_comb begin
    y = accept && fill_ok && (&bit_ok);
  end

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    hist_next    = hist_reg;
    fill_next    = fill_reg;
    err_next     = 1'b0;
    if (cfg_load) begin
      if (legal) begin
        state_next   = ARMED;
        pattern_next = cfg_pattern;
        len_next     = cfg_len;
        overlap_next = cfg_overlap;
        hist_next    = '0;
        fill_next    = '0;
      end else begin
        err_next = 1'b1;
      end
    end else if (accept) begin
      hist_next = window[MAX_LEN-2:0];
      if (y && !overlap_reg) begin
        fill_next = '0;
      end else if (fill_plus1 < {1'b0, len_reg}) begin
        fill_next = fill_plus1[LW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RST_STATE;
      pattern_reg <= DEF_PATTERN;
      len_reg     <= RST_LEN;
      overlap_reg <= DEF_OVERLAP;
      hist_reg    <= '0;
      fill_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      err_reg     <= err_next;
    end
  end

  assign cfg_err = err_reg;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (y),
    .clr   (cnt_clr),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: the driver predicts each cycle from a bit-queue model of
// the detector; a negedge monitor pops and compares y, match_cnt and cfg_err.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i;
  logic             in_valid;
  logic             cfg_load;
  logic [7:0]       cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i           (i),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .y           (y),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit y;
    int cnt;
    bit err;
    bit chk_regs;
    int id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  // Reference model: accepted bits since the last config/reset/consumed match.
  bit       m_armed;
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_q[$];
  int       m_cnt;
  bit       m_err;
  bit       m_known = 0;

  function automatic bit model_match(input bit ib);
    bit b;
    if (!m_armed) return 0;
    if (m_q.size() + 1 < m_len) return 0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? ib : m_q[m_q.size() - k];
      if (b != m_pat[k]) return 0;
    end
    return 1;
  endfunction

  task automatic step(input bit rn, input bit iv, input bit ib, input bit ld,
                      input logic [7:0] cp, input int cl, input bit co, input bit clr);
    exp_t e;
    bit   ey;
    rst_n = rn; in_valid = iv; i = ib; cfg_load = ld;
    cfg_pattern = cp; cfg_len = 4'(cl); cfg_overlap = co; cnt_clr = clr;
    ey = rn && iv && !ld && model_match(ib);
    e.y = ey; e.cnt = m_cnt; e.err = m_err; e.chk_regs = m_known; e.id = step_id;
    sb.push_back(e);
    step_id++;
    if (!rn) begin
      m_q.delete(); m_cnt = 0; m_err = 0; m_armed = 1;
      m_pat = 8'b0001_0110; m_len = 5; m_ovl = 1; m_known = 1;
    end else begin
      m_err = 0;
      if (ld) begin
        if (cl >= 1 && cl <= MAX_LEN) begin
          m_armed = 1; m_pat = cp; m_len = cl; m_ovl = co; m_q.delete();
        end else begin
          m_err = 1;
        end
      end else if (m_armed && iv) begin
        if (ey && !m_ovl) begin
          m_q.delete();
        end else begin
          m_q.push_back(ib);
          if (m_q.size() > 40) void'(m_q.pop_front());
        end
      end
      if (clr) m_cnt = 0;
      else if (ey && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1, 1, bits[k], 0, 8'h00, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (y !== e.y) begin
        failures++;
        $display("FAIL y step=%0d got=%b expected=%b", e.id, y, e.y);
      end else begin
        $display("step=%0d y=%b cnt=%0d err=%b ok", e.id, y, match_cnt, cfg_err);
      end
      if (e.chk_regs) begin
        checks++;
        if (match_cnt !== CNT_W'(e.cnt)) begin
          failures++;
          $display("FAIL match_cnt step=%0d got=%0d expected=%0d", e.id, match_cnt, e.cnt);
        end
        checks++;
        if (cfg_err !== e.err) begin
          failures++;
          $display("FAIL cfg_err step=%0d got=%b expected=%b", e.id, cfg_err, e.err);
        end
      end
    end
  end

  initial begin
    rst_n = 0; in_valid = 0; i = 0; cfg_load = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cnt_clr = 0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Default pattern 10110, single detection.
    send_bits(32'b10110, 5);
    idle(2);

    // Overlap on: two hits in 10110110.
    step(1, 0, 0, 0, 8'h00, 0, 0, 1);
    send_bits(32'b10110110, 8);
    idle(1);

    // Overlap off: one hit in the same stream.
    step(1, 0, 0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 0, 1, 8'b0001_0110, 5, 0, 0);
    send_bits(32'b10110110, 8);
    idle(1);

    // Illegal lengths are rejected; detection carries on unchanged.
    step(1, 0, 0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 0, 1, 8'hFF, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 1, 8'hFF, 9, 1, 0);
    send_bits(32'b10110, 5);
    idle(1);

    // Pattern 111, overlapping, five ones.
    step(1, 0, 0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 0, 1, 8'b0000_0111, 3, 1, 0);
    send_bits(32'b11111, 5);
    idle(1);

    // Reset discards a partial match.
    send_bits(32'b1011, 4);
    do_reset(1);
    send_bits(32'b0, 1);
    idle(1);

    // Saturation at 3, then clear coincident with a match.
    send_bits(32'b10110, 5);
    for (int k = 0; k < 4; k++) send_bits(32'b110, 3);
    idle(1);
    send_bits(32'b11, 2);
    step(1, 1, 0, 0, 8'h00, 0, 0, 1);
    idle(1);

    // Load together with the final bit: bit dropped, no hit.
    do_reset(1);
    send_bits(32'b1011, 4);
    step(1, 1, 0, 1, 8'b0001_0110, 5, 1, 0);
    idle(1);
    send_bits(32'b1011, 4);
    step(1, 1, 0, 1, 8'h00, 0, 1, 0);
    idle(2);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      bit rn, iv, ib, ld, co, clr;
      int cl;
      logic [7:0] cp;
      rn  = ($urandom_range(0, 99) >= 2);
      iv  = ($urandom_range(0, 99) < 75);
      ib  = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 99) < 4);
      co  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 99) < 6);
      cl  = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) cl = $urandom_range(1, 3);
      cp  = 8'($urandom);
      step(rn, iv, ib, ld, cp, cl, co, clr);
    end
    idle(1);

    #6;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
